// File: rtl/osc_pkg.sv
// osc_pkg: shared FSM state type and default parameter values for osc_sampler.
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECORD  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } osc_state_e;

  localparam int OSC_COUNTER_LENGTH = 16;
  localparam int OSC_WINDOW_CYCLES  = 1024;
  localparam int OSC_RESP_BITS      = 32;
  localparam int OSC_MAX_WINDOWS    = 256;

endpackage

// File: rtl/osc_debias.sv
// osc_debias: von Neumann pair filter. Raw bits are taken in pairs (a, b);
// (1,0) emits 1, (0,1) emits 0, equal pairs emit nothing. The emitted bit is
// presented combinationally in the same cycle as the second bit of the pair.
module osc_debias (
  input  logic CLOCK,
  input  logic RESET,
  input  logic bit_in,
  input  logic bit_vld,
  output logic bit_out,
  output logic bit_out_vld
);

  logic r_have_a;
  logic r_a;

  // Hold the first bit of each pair until its partner arrives.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_have_a <= 1'b0;
      r_a      <= 1'b0;
    end else if (bit_vld) begin
      if (r_have_a) begin
        r_have_a <= 1'b0;
      end else begin
        r_have_a <= 1'b1;
        r_a      <= bit_in;
      end
    end
  end

  assign bit_out     = r_a;
  assign bit_out_vld = bit_vld & r_have_a & (r_a ^ bit_in);

endmodule

// File: rtl/osc_sampler.sv
// osc_sampler: gates an upstream oscillator bank with RECORDING windows and
// turns window-to-window count increases into response bits.
// Optional feature: define OSC_SAMPLER_DEBIAS_EN to pass raw bits through the
// osc_debias pair filter; a response may then run out of windows (RESP_ERR).
module osc_sampler
  import osc_pkg::*;
#(
  parameter int COUNTER_LENGTH = OSC_COUNTER_LENGTH,
  parameter int WINDOW_CYCLES  = OSC_WINDOW_CYCLES,
  parameter int RESP_BITS      = OSC_RESP_BITS,
  parameter int MAX_WINDOWS    = OSC_MAX_WINDOWS
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [COUNTER_LENGTH-1:0] BANK_SUM,
  output logic                      RECORDING,
  output logic [RESP_BITS-1:0]      RESP,
  output logic                      RESP_VALID,
  input  logic                      RESP_READY,
  output logic                      RESP_ERR,
  output logic                      BUSY
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam int BW = $clog2(RESP_BITS + 1);
  localparam int WW = $clog2(MAX_WINDOWS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(WINDOW_CYCLES - 1);
  localparam logic [BW-1:0] BITS_TGT = BW'(RESP_BITS);
  localparam logic [WW-1:0] WIN_TGT  = WW'(MAX_WINDOWS);

  osc_state_e                r_state;
  logic [CW-1:0]             r_cyc;
  logic [BW-1:0]             r_bits;
  logic [WW-1:0]             r_win;
  logic                      r_first;
  logic [COUNTER_LENGTH-1:0] r_prev;
  logic [RESP_BITS-1:0]      r_resp;
  logic                      r_rec;
  logic                      r_valid;

  logic          w_raw, w_raw_vld;
  logic          w_bit, w_bit_vld;
  logic [BW-1:0] w_bits_nxt;
  logic [WW-1:0] w_win_nxt;
  logic          w_done, w_exh;

  // The first window of a response only seeds prev; later windows compare.
  assign w_raw      = BANK_SUM > r_prev;
  assign w_raw_vld  = (r_state == ST_CAPTURE) & ~r_first;
  assign w_bits_nxt = r_bits + BW'(w_bit_vld);
  assign w_win_nxt  = r_win + WW'(1);
  assign w_done     = (w_bits_nxt == BITS_TGT);
  assign w_exh      = (w_win_nxt == WIN_TGT);

`ifdef OSC_SAMPLER_DEBIAS_EN
  logic r_db_run;
  logic r_err;

  // The pair filter is held in reset outside a response so a half pair left
  // by an exhausted response never pairs with the next response's bits.
  osc_debias u_debias (
    .CLOCK       (CLOCK),
    .RESET       (r_db_run),
    .bit_in      (w_raw),
    .bit_vld     (w_raw_vld),
    .bit_out     (w_bit),
    .bit_out_vld (w_bit_vld)
  );

  // Pair-filter run enable and error flag for window-budget exhaustion.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_db_run <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == ST_IDLE && START) begin
      r_db_run <= 1'b1;
      r_err    <= 1'b0;
    end else if (r_state == ST_CAPTURE && !w_done && w_exh) begin
      r_err    <= 1'b1;
    end else if (r_state == ST_HOLD && RESP_READY) begin
      r_db_run <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign RESP_ERR = r_err;
`else
  assign w_bit     = w_raw;
  assign w_bit_vld = w_raw_vld;
  assign RESP_ERR  = 1'b0;
`endif

  // Main sequencer: record window, capture, repeat until full or out of budget.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_bits  <= '0;
      r_win   <= '0;
      r_first <= 1'b0;
      r_prev  <= '0;
      r_resp  <= '0;
      r_rec   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state <= ST_RECORD;
            r_rec   <= 1'b1;
            r_cyc   <= '0;
            r_bits  <= '0;
            r_win   <= '0;
            r_resp  <= '0;
            r_first <= 1'b1;
          end
        end
        ST_RECORD: begin
          if (r_cyc == CYC_LAST) begin
            r_state <= ST_CAPTURE;
            r_rec   <= 1'b0;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        ST_CAPTURE: begin
          r_prev  <= BANK_SUM;
          r_first <= 1'b0;
          r_win   <= w_win_nxt;
          if (w_bit_vld) begin
            r_resp <= (r_resp << 1) | RESP_BITS'(w_bit);
            r_bits <= w_bits_nxt;
          end
          if (w_done || w_exh) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_RECORD;
            r_rec   <= 1'b1;
            r_cyc   <= '0;
          end
        end
        ST_HOLD: begin
          if (RESP_READY) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RECORDING  = r_rec;
  assign RESP       = r_resp;
  assign RESP_VALID = r_valid;
  assign BUSY       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_osc_sampler.sv
// tb_osc_sampler: directed + randomized checks of osc_sampler against a
// window-level reference model (builds with or without OSC_SAMPLER_DEBIAS_EN).
module tb_osc_sampler;

  localparam int W  = 4;
  localparam int R  = 4;
  localparam int MW = 12;
  localparam int CL = 16;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic          RESP_READY = 1'b1;
  logic [CL-1:0] BANK_SUM = '0;
  logic          RECORDING, RESP_VALID, RESP_ERR, BUSY;
  logic [R-1:0]  RESP;

  int checks = 0;
  int errors = 0;
  int unsigned vals[MW];

  osc_sampler #(
    .COUNTER_LENGTH (CL),
    .WINDOW_CYCLES  (W),
    .RESP_BITS      (R),
    .MAX_WINDOWS    (MW)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .START      (START),
    .BANK_SUM   (BANK_SUM),
    .RECORDING  (RECORDING),
    .RESP       (RESP),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP_ERR   (RESP_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: window i captures vals[i]; later windows give raw bit
  // vals[i] > vals[i-1]; bits optionally von Neumann filtered per response.
  function automatic void model(output logic [R-1:0] resp, output bit err, output int nwin);
    int bits;
    bit have, a, raw, emit, eb;
    bits = 0; have = 0; a = 0; resp = '0; err = 0; nwin = 0;
    for (int i = 0; i < MW; i++) begin
      nwin = i + 1;
      if (i > 0) begin
        raw  = (vals[i] > vals[i-1]);
        emit = 0; eb = 0;
`ifdef OSC_SAMPLER_DEBIAS_EN
        if (!have) begin
          have = 1; a = raw;
        end else begin
          have = 0;
          if (a != raw) begin emit = 1; eb = a; end
        end
`else
        emit = 1; eb = raw;
`endif
        if (emit) begin
          resp = {resp[R-2:0], eb};
          bits++;
        end
        if (bits == R) return;
      end
      if (nwin == MW) begin
        err = 1;
        return;
      end
    end
  endfunction

  // One full response: START, feed one BANK_SUM value per capture, check
  // window length, latency, result and the HOLD handshake.
  task automatic run(input int rdy_delay, input bit poke, output logic [R-1:0] got, output int lat);
    logic [R-1:0] eresp;
    bit  eerr, prev_rec, seen;
    int  enw, cyc, k, run_len;
    model(eresp, eerr, enw);
    RESP_READY = (rdy_delay == 0);
    START = 1'b1;
    step();
    START = 1'b0;
    cyc = 1; k = 0; run_len = 0; prev_rec = 0; seen = 0;
    chk("busy_after_start", BUSY, 1);
    while (cyc < 2000) begin
      if (RESP_VALID) begin seen = 1; break; end
      if (RECORDING) run_len++;
      else if (prev_rec) begin
        chk("rec_len", run_len, W);
        run_len = 0;
        if (k < MW) BANK_SUM = CL'(vals[k]);
        k++;
      end
      prev_rec = RECORDING;
      START = poke && (cyc == 2);
      step();
      cyc++;
    end
    START = 1'b0;
    got = RESP;
    lat = cyc;
    chk("valid_seen", seen, 1);
    chk("latency", cyc, enw * (W + 1) + 1);
    chk("windows", k, enw);
    chk("resp", RESP, eresp);
`ifdef OSC_SAMPLER_DEBIAS_EN
    chk("err", RESP_ERR, eerr);
`else
    chk("err", RESP_ERR, 0);
`endif
    chk("busy_hold", BUSY, 1);
    if (rdy_delay == 0) begin
      step();
      chk("valid_drop", RESP_VALID, 0);
    end else begin
      for (int i = 0; i < rdy_delay; i++) begin
        START = poke && (i == 1);
        step();
        chk("hold_valid", RESP_VALID, 1);
        chk("hold_resp", RESP, eresp);
      end
      START = 1'b0;
      RESP_READY = 1'b1;
      step();
      chk("valid_drop", RESP_VALID, 0);
    end
    chk("busy_idle", BUSY, 0);
    repeat (3) step();
    chk("single_resp", {BUSY, RESP_VALID, RECORDING}, 0);
  endtask

  initial begin
    logic [R-1:0] got;
    int lat;

    // Reset state, then quiet after release until START.
    repeat (2) step();
    chk("rst_out", {RECORDING, RESP_VALID, RESP_ERR, BUSY, RESP}, 0);
    RESET = 1'b1;
    repeat (3) step();
    chk("idle_quiet", {RECORDING, RESP_VALID, RESP_ERR, BUSY, RESP}, 0);

    // Directed: 10,12,11,11,20 with READY high.
    vals[0] = 10; vals[1] = 12; vals[2] = 11; vals[3] = 11; vals[4] = 20;
    for (int i = 5; i < MW; i++) vals[i] = 20 - i;
    run(0, 0, got, lat);
`ifndef OSC_SAMPLER_DEBIAS_EN
    chk("dir_resp_1001", got, 4'b1001);
    chk("dir_latency_26", lat, 26);
`endif

    // Held-off READY with ignored START pulses in RECORD and HOLD.
    for (int i = 0; i < MW; i++) vals[i] = $urandom_range(0, 15);
    run(5, 1, got, lat);

    // Reset in cycle 2 of a window, then a clean response.
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    chk("pre_rst_rec", RECORDING, 1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_out", {RECORDING, RESP_VALID, RESP_ERR, BUSY, RESP}, 0);
    step();
    RESET = 1'b1;
    step();
    chk("post_rst_out", {RECORDING, RESP_VALID, RESP_ERR, BUSY, RESP}, 0);
    for (int i = 0; i < MW; i++) vals[i] = $urandom_range(0, 15);
    run(0, 0, got, lat);

    // Constant BANK_SUM: all ties.
    for (int i = 0; i < MW; i++) vals[i] = 7;
    run(0, 0, got, lat);
    chk("const_resp", got, 0);

    // Randomized responses with small value range so ties are common.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < MW; i++) vals[i] = $urandom_range(0, 7);
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), got, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osc_sampler.md
OSC_SAMPLER -- requirements
Module: osc_sampler

Interface
REQ-001 Parameter COUNTER_LENGTH, default 16: width of the BANK_SUM input.
REQ-002 Parameter WINDOW_CYCLES, default 1024: number of cycles RECORDING stays high per measurement window, at least 2.
REQ-003 Parameter RESP_BITS, default 32: response word width.
REQ-004 Parameter MAX_WINDOWS, default 256: window budget per response; must be at least RESP_BITS+1.
REQ-005 Port CLOCK, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 Port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port START, input, 1 bit: requests one response; single-cycle pulse or level.
REQ-008 Port BANK_SUM, input, COUNTER_LENGTH bits: accumulated count from the upstream oscillator bank.
REQ-009 Port RECORDING, output, 1 bit: gates accumulation in the upstream bank.
REQ-010 Port RESP, output, RESP_BITS bits: response word.
REQ-011 Port RESP_VALID, output, 1 bit: RESP and RESP_ERR are valid.
REQ-012 Port RESP_READY, input, 1 bit: consumer accepts the response.
REQ-013 Port RESP_ERR, output, 1 bit: window budget exhausted before the response was complete.
REQ-014 Port BUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RECORD, CAPTURE and HOLD.
REQ-016 IDLE -> RECORD on any edge where START=1: clears the bit counter, window counter, RESP and the first-window flag.
REQ-017 START SHALL be ignored in every state other than IDLE.
REQ-018 RECORDING SHALL be a registered output, high exactly while in RECORD, for exactly WINDOW_CYCLES consecutive cycles.
REQ-019 RECORD -> CAPTURE after WINDOW_CYCLES cycles.
REQ-020 In CAPTURE, the first cycle with RECORDING low, BANK_SUM SHALL be latched into register prev; CAPTURE lasts one cycle.
REQ-021 The first window of each response SHALL only load prev and SHALL produce no bit.
REQ-022 Each later window SHALL produce raw bit = 1 if BANK_SUM > prev (unsigned), else 0; a tie gives 0.
REQ-023 Each produced bit SHALL shift into RESP at the LSB, so the earliest bit ends at the MSB.
REQ-024 The window counter SHALL increment in every CAPTURE cycle.
REQ-025 After CAPTURE, the FSM SHALL go to HOLD if RESP_BITS bits have been collected, or to HOLD with RESP_ERR=1 if the window count equals MAX_WINDOWS; otherwise it SHALL return to RECORD.
REQ-026 When RESP_ERR=1, RESP SHALL hold the partial bits collected.
REQ-027 In HOLD, RESP_VALID SHALL be 1, and RESP and RESP_ERR SHALL remain stable until the edge where RESP_READY=1.
REQ-028 At that edge the FSM SHALL go to IDLE, and RESP_VALID SHALL be 0 on the next cycle.
REQ-029 If RESP_READY is already 1 on entry to HOLD, the handshake SHALL complete after exactly one valid cycle.
REQ-030 Response latency with no debias and ready held high: (RESP_BITS+1)*(WINDOW_CYCLES+1)+1 cycles from the START edge to RESP_VALID.

Reset
REQ-031 Asserting RESET low, including mid-window, SHALL immediately force: state IDLE, RECORDING=0, RESP=0, RESP_VALID=0, RESP_ERR=0, BUSY=0, and all counters and prev cleared.
REQ-032 Reset deassertion SHALL take effect on a clock edge, and no output SHALL change before the first START.

Configuration
REQ-033 The compile macro is OSC_SAMPLER_DEBIAS_EN.
REQ-034 With OSC_SAMPLER_DEBIAS_EN defined, raw bits SHALL be paired in order (a, b).
REQ-035 For a debiased pair, (0,1) SHALL emit 0, (1,0) SHALL emit 1, and (0,0) or (1,1) SHALL emit nothing.
REQ-036 Only emitted bits SHALL count toward RESP_BITS, and RESP_ERR is then reachable.
REQ-037 Without OSC_SAMPLER_DEBIAS_EN, every raw bit SHALL be emitted, and RESP_ERR SHALL be constant 0.

Structure
REQ-038 Shared package osc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-039 The von Neumann pair filter SHALL be sub-module osc_debias, with inputs CLOCK, RESET, bit_in and bit_vld, and outputs bit_out and bit_out_vld.
REQ-040 osc_debias SHALL be instantiated only under OSC_SAMPLER_DEBIAS_EN.

Verification
REQ-041 Scenario, no debias, WINDOW_CYCLES=4, RESP_BITS=4: BANK_SUM sequence 10,12,11,11,20 with RESP_READY=1 -> RESP=4'b1001, RESP_VALID at cycle 26, and RECORDING high for 4 cycles per window.
REQ-042 Scenario: hold RESP_READY=0 for 5 cycles in HOLD -> RESP_VALID and RESP stay stable, and IDLE is reached one edge after RESP_READY=1.
REQ-043 Scenario: START pulses during RECORD and HOLD -> ignored, and exactly one response is produced.
REQ-044 Scenario: RESET low in cycle 2 of a window -> RECORDING=0 in the same cycle, all outputs 0, and a new START yields a correct response.
REQ-045 Scenario, debias, RESP_BITS=2: raw bits 1,0,1,1,0,1 -> RESP=2'b10 after 7 windows.
REQ-046 Scenario, debias, MAX_WINDOWS=5: constant BANK_SUM -> RESP_VALID=1, RESP_ERR=1 and RESP=0 after 5 windows.
